// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI4 slave SRAM model serving 32-bit aligned words.
// Latency: rvalid RD_LAT+1 cycles after AR handshake, bvalid WR_LAT+1 cycles after W handshake.
// Backpressure: one transaction at a time; R/B responses held until rready/bready.
//
// Ports: clock/reset (async active-high), io_slave_aw*/w*/b* write channels,
//        io_slave_ar*/r* read channels. Bursts are rejected with SLVERR, unmapped
//        addresses with DECERR. Optional feature macro: AXI_SRAM_RAND_DELAY_EN adds
//        an LFSR-driven random extra latency of 0..7 cycles.
module axi_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_slave_awvalid,
    output logic        io_slave_awready,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    input  logic        io_slave_wvalid,
    output logic        io_slave_wready,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    output logic        io_slave_bvalid,
    input  logic        io_slave_bready,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    input  logic        io_slave_arvalid,
    output logic        io_slave_arready,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    output logic        io_slave_rvalid,
    input  logic        io_slave_rready,
    output logic [31:0] io_slave_rdata,
    output logic [1:0]  io_slave_rresp,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] WINDOW = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [7:0]  RD_LAT8 = 8'(RD_LAT);
    localparam logic [7:0]  WR_LAT8 = 8'(WR_LAT);

    typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, W_RESP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d, bresp_q, bresp_d;
    logic [3:0]        rid_q, rid_d, bid_q, bid_d;
    logic              rvalid_q, rvalid_d, rlast_q, rlast_d, bvalid_q, bvalid_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [32:0]       ar_off, aw_off;
    logic [1:0]        ar_resp, aw_resp;
    logic [7:0]        rd_lat_ld, wr_lat_ld;
    logic              wr_en;
    logic              unused_ok;

    // 33-bit offset: bit 32 set means the address lies below ADDR_BASE.
    assign ar_off  = {1'b0, io_slave_araddr} - {1'b0, ADDR_BASE};
    assign aw_off  = {1'b0, io_slave_awaddr} - {1'b0, ADDR_BASE};
    assign ar_resp = (ar_off[32] || ar_off >= WINDOW) ? 2'b11 :
                     (io_slave_arlen != 8'd0)          ? 2'b10 : 2'b00;
    assign aw_resp = (aw_off[32] || aw_off >= WINDOW) ? 2'b11 :
                     (io_slave_awlen != 8'd0)          ? 2'b10 : 2'b00;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [8:0] rd_sum, wr_sum;

    always_comb begin
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rd_sum    = {1'b0, RD_LAT8} + {6'd0, lfsr_q[2:0]};
        wr_sum    = {1'b0, WR_LAT8} + {6'd0, lfsr_q[2:0]};
        rd_lat_ld = rd_sum[8] ? 8'hFF : rd_sum[7:0];
        wr_lat_ld = wr_sum[8] ? 8'hFF : wr_sum[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign rd_lat_ld = RD_LAT8;
    assign wr_lat_ld = WR_LAT8;
`endif

    // Ready signals are decoded from state; gating with reset keeps them low
    // for the whole reset interval even though state sits at IDLE.
    assign io_slave_arready = ~reset & (state_q == IDLE);
    assign io_slave_awready = ~reset & (state_q == IDLE) & ~io_slave_arvalid;
    assign io_slave_wready  = ~reset & (state_q == W_DATA);

    assign io_slave_rvalid = rvalid_q;
    assign io_slave_rlast  = rlast_q;
    assign io_slave_rdata  = rdata_q;
    assign io_slave_rresp  = rresp_q;
    assign io_slave_rid    = rid_q;
    assign io_slave_bvalid = bvalid_q;
    assign io_slave_bresp  = bresp_q;
    assign io_slave_bid    = bid_q;

    assign wr_en = io_slave_wready & io_slave_wvalid & (bresp_q == 2'b00);

    assign unused_ok = ^{io_slave_awsize, io_slave_awburst, io_slave_arsize,
                         io_slave_arburst, io_slave_wlast, ar_off[1:0], aw_off[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rid_d    = rid_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        bresp_d  = bresp_q;
        bid_d    = bid_q;
        bvalid_d = bvalid_q;
        case (state_q)
            IDLE: begin
                if (io_slave_arvalid) begin
                    state_d = R_WAIT;
                    cnt_d   = rd_lat_ld;
                    idx_d   = ar_off[IDX_W+1:2];
                    rresp_d = ar_resp;
                    rid_d   = io_slave_arid;
                end else if (io_slave_awvalid) begin
                    state_d = W_DATA;
                    idx_d   = aw_off[IDX_W+1:2];
                    bresp_d = aw_resp;
                    bid_d   = io_slave_awid;
                end
            end
            R_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d  = R_RESP;
                    rvalid_d = 1'b1;
                    rlast_d  = 1'b1;
                    rdata_d  = (rresp_q == 2'b00) ? mem[idx_q] : 32'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            R_RESP: begin
                if (io_slave_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end
            end
            W_DATA: begin
                if (io_slave_wvalid) begin
                    state_d = W_WAIT;
                    cnt_d   = wr_lat_ld;
                end
            end
            W_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d  = W_RESP;
                    bvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (io_slave_bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            rdata_q  <= 32'd0;
            rresp_q  <= 2'b00;
            rid_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            bresp_q  <= 2'b00;
            bid_q    <= 4'd0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rid_q    <= rid_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            bresp_q  <= bresp_d;
            bid_q    <= bid_d;
            bvalid_q <= bvalid_d;
        end
    end

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (io_slave_wstrb[i]) mem[idx_q][8*i +: 8] <= io_slave_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave memory model that sits directly downstream of the core's AXI master port and serves both instruction fetches and LSU loads/stores. It accepts one transaction at a time, applies a configurable response latency, and returns full aligned 32-bit words; byte-lane shifting stays in the master. Addresses outside the mapped window get a DECERR response.

## Interface
- ADDR_BASE, 32'h8000_0000: first byte address mapped.
- DEPTH_WORDS, 4096: number of 32-bit words; mapped window is [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).
- RD_LAT, 1: extra wait cycles before rvalid (0..255).
- WR_LAT, 1: extra wait cycles before bvalid (0..255).
- Clock and reset: one clock, `clock`; reset `reset` is asynchronous and active-high.
- clock  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- io_slave_awvalid/awready  in/out  1/1  AW handshake.
- io_slave_awaddr/awid/awlen/awsize/awburst  input  32/4/8/3/2  write address info.
- io_slave_wvalid/wready  in/out  1/1  W handshake.
- io_slave_wdata/wstrb/wlast  input  32/4/1  write data, byte strobes, last beat.
- io_slave_bvalid/bready  out/in  1/1  B handshake.
- io_slave_bresp/bid  output  2/4  write response, echoed awid.
- io_slave_arvalid/arready  in/out  1/1  AR handshake.
- io_slave_araddr/arid/arlen/arsize/arburst  input  32/4/8/3/2  read address info.
- io_slave_rvalid/rready  out/in  1/1  R handshake.
- io_slave_rdata/rresp/rlast/rid  output  32/2/1/4  read data, response, last, echoed arid.

## Operation
- States: IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, W_RESP. One outstanding transaction.
- IDLE: arready=1. awready=1 only when arvalid=0, so a read wins when both are valid in the same cycle.
- AR handshake: capture the address, arid, and range/len check. Load the latency counter with RD_LAT, then go to R_WAIT.
- R_WAIT: decrement the counter. At 0, go to R_RESP.
- R_RESP: rvalid=1, rlast=1, rid=captured id. rdata and rresp are registered and held stable until rready. On handshake, go to IDLE.
- Word index = (addr − ADDR_BASE)>>2, addr[1:0] ignored. rdata is the full word regardless of arsize.
- rresp/bresp encoding:
  - Out of range: 2'b11 (DECERR), rdata=0.
  - arlen≠0 or awlen≠0: 2'b10 (SLVERR), single beat only, no memory write.
  - Otherwise: 2'b00.
- AW handshake: capture address, awid, and checks, then go to W_DATA.
- W_DATA: wready=1. On wvalid, write byte lanes where wstrb[i]=1 if OKAY, else no write. Load the counter with WR_LAT and go to W_WAIT. wlast is not checked.
- W_WAIT: count down to 0, then go to W_RESP.
- W_RESP: bvalid=1 with bresp/bid held until bready, then go to IDLE.
- The memory array is not reset; contents survive reset.

## Timing
- Reset values (asynchronous, immediate): every valid/ready output is 0; rdata, rresp, rid, bresp, bid are 0; rlast is 0; state is IDLE.
- Read latency: rvalid rises RD_LAT+1 cycles after the AR handshake edge. Example: RD_LAT=0 gives rvalid in the cycle after the handshake.
- Write latency: bvalid rises WR_LAT+1 cycles after the W handshake edge.
- The earliest next AR/AW acceptance is the cycle after the R/B handshake.
- Reset mid-transaction aborts it:
  - No response is issued.
  - A W beat whose handshake edge coincides with reset assertion is not written.
- Counter is 8 bits wide and never wraps. Loading occurs only on a handshake.

## Configuration
- AXI_SRAM_RAND_DELAY_EN defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5; advances every cycle).
  - Loaded latency = RD_LAT/WR_LAT + lfsr[2:0], saturating at 255.
- Not defined: latency is exactly RD_LAT/WR_LAT and no LFSR is present.

## Test plan
- Full-word write: 0xDEADBEEF to 0x8000_0000, wstrb=4'b1111 -> bresp=00 and bid equal to awid. Read back -> rdata=0xDEADBEEF, rresp=00, rlast=1, rvalid exactly RD_LAT+1 cycles after AR.
- Byte-lane write: word 0x11223344 at 0x8000_0004, then wdata=0x00AA0000 with wstrb=4'b0100 -> read returns 0x11AA3344. A read of 0x8000_0006 with arsize=1 returns the same word.
- Out-of-range access: read 0x2000_0000 -> rresp=11, rdata=0. Write 0x7FFF_FFFC -> bresp=11 and memory unchanged. arlen=3 -> rresp=10 with a single beat.
- Simultaneous AR and AW in IDLE: arvalid and awvalid both asserted -> awready=0 until the read's R handshake completes, then the AW is accepted.
- Backpressure: hold rready=0 for 5 cycles (likewise bready) -> rvalid and rdata stay stable; the transaction completes on the first ready cycle.
- Reset mid-operation: assert reset in W_WAIT -> all outputs 0 in the same cycle and no bvalid afterwards. After deassertion, a read of the previously written word returns the pre-reset contents.
